// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory controller: funct3 encodings,
// controller state and datapath widths.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the load/store stage (master) and the data memory (slave).
interface dmem_ctrl_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [2:0]        req_fun3;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_fun3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_fun3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and lane replication, load extraction with
// sign/zero extension, and misalignment / illegal-funct3 detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        i_addr_lo,
  input  logic [2:0]        i_fun3,
  input  logic              i_we,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [WORD_W-1:0] i_raw,
  output logic [BE_W-1:0]   o_be,
  output logic [WORD_W-1:0] o_wdata,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_misalign,
  output logic              o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_raw[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_raw[{i_addr_lo[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    o_be       = '0;
    o_wdata    = '0;
    o_rdata    = '0;
    o_misalign = 1'b0;
    o_illegal  = 1'b0;
    if (i_we) begin
      case (i_fun3)
        F3_B: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_wdata[7:0]}};
        end
        F3_H: begin
          o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata    = {2{i_wdata[15:0]}};
          o_misalign = i_addr_lo[0];
        end
        F3_W: begin
          o_be       = 4'b1111;
          o_wdata    = i_wdata;
          o_misalign = |i_addr_lo;
        end
        default: o_illegal = 1'b1;
      endcase
    end else begin
      case (i_fun3)
        F3_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
        F3_BU: o_rdata = {24'h0, w_byte};
        F3_H: begin
          o_rdata    = {{16{w_half[15]}}, w_half};
          o_misalign = i_addr_lo[0];
        end
        F3_HU: begin
          o_rdata    = {16'h0, w_half};
          o_misalign = i_addr_lo[0];
        end
        F3_W: begin
          o_rdata    = i_raw;
          o_misalign = |i_addr_lo;
        end
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: IDLE/BUSY/RESP sequencer with wait-state counter, range check,
// byte-enabled word array and a registered one-cycle response.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter logic [WORD_W-1:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned       WAIT_STATES = 0
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  dmem_state_t       r_state;
  logic [3:0]        r_wait;
  logic              r_we;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [2:0]        r_fun3;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [WORD_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  logic [WORD_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [WORD_W-1:0] w_raw;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rdata;
  logic [BE_W-1:0]   w_be;
  logic              w_oor;
  logic              w_misalign;
  logic              w_illegal;
  logic              w_err;
  logic              w_access;
  logic              w_commit;

  // Unsigned offset from the base; addresses below the base are caught explicitly
  // because the subtraction would otherwise wrap to a large in-range-looking value.
  assign w_off    = r_addr - ADDR_BASE;
  assign w_oor    = (r_addr < ADDR_BASE) || ((w_off >> 2) >= DEPTH_WORDS);
  assign w_idx    = w_off[IDX_W+1:2];
  assign w_raw    = r_mem[w_idx];
  assign w_err    = w_oor | w_misalign | w_illegal;
  assign w_access = (r_state == BUSY) && (r_wait == 4'd0);
  assign w_commit = w_access && r_we && !w_err;

  dmem_lane_align u_align (
    .i_addr_lo  (r_addr[1:0]),
    .i_fun3     (r_fun3),
    .i_we       (r_we),
    .i_wdata    (r_wdata),
    .i_raw      (w_raw),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  // NOTE: the array has no reset branch so it maps onto plain RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < BE_W; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_fun3      <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_fun3      <= bus.req_fun3;
            r_wait      <= WAIT_LOAD;
            r_req_ready <= 1'b0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            r_rsp_rdata <= (w_err || r_we) ? '0 : w_rdata;
            r_rsp_err   <= w_err;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule
